// File: rtl/rom_stream_pkg.sv
// Shared definitions for the burst-read lookup memory: FSM state encodings and
// the formula that sets the initial memory contents.
package rom_stream_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    // Returns (base + idx*stride) mod 2**width; values wrap at the word width.
    function automatic int unsigned init_word(
        input int unsigned base,
        input int unsigned stride,
        input int unsigned idx,
        input int unsigned width
    );
        int unsigned mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (base + idx * stride) & mask;
    endfunction

endpackage

// File: rtl/rom_array.sv
// Writable lookup storage with one write port and one registered, enabled read port.
// Contents start from the package init formula; reset clears only the read register.
module rom_array
    import rom_stream_pkg::*;
#(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned INIT_BASE   = 0,
    parameter int unsigned INIT_STRIDE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic mem_t init_mem();
        mem_t m;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            m[i[ADDR_W-1:0]] = DATA_W'(init_word(INIT_BASE, INIT_STRIDE, i, DATA_W));
        end
        return m;
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH] = init_mem();
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking update gives read-before-write on a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/rom_burst_streamer.sv
// Burst-read sequencer over rom_array: accepts start address and length, then streams
// consecutive words (wrapping at the top) on a valid/ready channel with backpressure.
module rom_burst_streamer
    import rom_stream_pkg::*;
#(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned INIT_BASE   = 0,
    parameter int unsigned INIT_STRIDE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              done,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_last;
    logic              r_done;

    logic [ADDR_W:0]   w_len_sat;
    logic              w_hs;
    logic              w_fetch;
    logic [DATA_W-1:0] w_rd_data;

    assign w_len_sat = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    assign w_hs      = r_out_valid && out_ready;
    assign w_fetch   = (r_state == ST_STREAM) && (r_remaining != '0) &&
                       (!r_out_valid || out_ready);

    rom_array #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .INIT_BASE   (INIT_BASE),
        .INIT_STRIDE (INIT_STRIDE)
    ) u_rom_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (w_fetch),
        .rd_addr (r_cur_addr),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_cur_addr  <= cmd_addr;
                        r_remaining <= w_len_sat;
                        if (w_len_sat != '0) begin
                            r_state <= ST_STREAM;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_fetch) begin
                        r_out_valid <= 1'b1;
                        r_out_addr  <= r_cur_addr;
                        r_out_last  <= (r_remaining == LEN_ONE);
                        r_cur_addr  <= r_cur_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                    end else if (w_hs) begin
                        r_out_valid <= 1'b0;
                    end
                    // The last beat leaves remaining at zero, so no fetch competes here.
                    if (w_hs && r_out_last) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = w_rd_data;
    assign out_addr  = r_out_addr;
    assign out_last  = r_out_last;
    assign done      = r_done;

endmodule
